// File: rtl/sram_controller.sv
// Multi-cycle controller between the MEM pipeline stage and a 64x32 data SRAM.
// Each request is latched in IDLE, held for WAIT_CYCLES ACCESS cycles, then acknowledged in DONE.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic        op_write;
  logic        request;
  logic        start;
  logic        last;
  logic [5:0]  word_address;

  assign request = rd_en | wr_en;
  assign start   = (state == IDLE) && request;
  assign last    = (state == ACCESS) && (count == LAST_COUNT);

  // Modulo-2^32 offset from the data segment base; byte bits dropped, upper bits wrap.
  assign word_address = 6'((address - BASE_ADDR) >> 2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state and outputs get defaults first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~request;
        if (request) state_next = ACCESS;
      end
      ACCESS: begin
        mem_read  = ~op_write;
        mem_write = op_write & last;
        if (last) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (start) begin
      count <= 4'd0;
    end else if (state == ACCESS) begin
      count <= count + 4'd1;
    end
  end

  // A simultaneous read+write request is treated as a write only.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write    <= 1'b0;
      mem_address <= 6'd0;
      mem_data    <= 32'd0;
    end else if (start) begin
      op_write    <= wr_en;
      mem_address <= word_address;
      mem_data    <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (last && !op_write) begin
      read_data <= mem_result;
    end
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 4: number of ACCESS cycles per transaction, legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 1024: byte address mapped to data-memory word 0.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rd_en  input  1  MEM-stage load request.
REQ-006 wr_en  input  1  MEM-stage store request.
REQ-007 address  input  32  ALU-computed byte address.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  registered load result.
REQ-010 ready  output  1  transaction complete or idle; pipeline freeze = ~ready.
REQ-011 mem_read  output  1  read strobe to the 64x32 data memory.
REQ-012 mem_write  output  1  write strobe to the data memory.
REQ-013 mem_address  output  6  word address to the data memory.
REQ-014 mem_data  output  32  write data to the data memory.
REQ-015 mem_result  input  32  read data from the data memory, valid while mem_read is high.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-017 IDLE: with rd_en=0 and wr_en=0, the FSM SHALL stay in IDLE with ready=1.
REQ-018 IDLE: with rd_en or wr_en asserted, ready SHALL be 0 in that same cycle (combinational), and the FSM SHALL enter ACCESS on the next edge.
REQ-019 On that edge the block SHALL latch address, write_data and op type into internal registers; later input changes SHALL have no effect until IDLE.
REQ-020 Word address SHALL be bits [7:2] of (address - BASE_ADDR), 32-bit modulo subtraction; bits [1:0] are ignored and out-of-range addresses wrap within 64 words.
REQ-021 If rd_en and wr_en are both 1 in IDLE, the block SHALL perform a write only.
REQ-022 ACCESS SHALL last exactly WAIT_CYCLES cycles, timed by a 4-bit counter cleared on ACCESS entry; ready SHALL be 0 throughout.
REQ-023 During ACCESS, mem_address and mem_data SHALL hold the latched values; in IDLE and DONE they SHALL hold their last values.
REQ-024 Load: mem_read SHALL be 1 in every ACCESS cycle and 0 otherwise; in the last ACCESS cycle, mem_result SHALL be captured into read_data.
REQ-025 Store: mem_write SHALL be 1 only in the last ACCESS cycle, giving exactly one write per store; mem_read SHALL stay 0.
REQ-026 read_data SHALL be unchanged by stores and hold its value until the next load completes.
REQ-027 DONE SHALL last one cycle with ready=1, then return to IDLE unconditionally; requests seen in DONE SHALL be ignored.
REQ-028 Latency: request cycle 0 = IDLE; cycles 1..WAIT_CYCLES = ACCESS; cycle WAIT_CYCLES+1 = DONE.
REQ-029 Back-to-back requests SHALL have at least one IDLE cycle between DONE and the next ACCESS.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, counter=0, read_data=0, mem_read=0, mem_write=0, mem_address=0, mem_data=0 on that edge.
REQ-031 The block SHALL give ready=1 in the first cycle after reset when no request is present.
REQ-032 Reset during ACCESS SHALL abort the transaction; no mem_write pulse SHALL occur for it, and read_data SHALL be 0.
REQ-033 rst SHALL take priority over every request input in the same cycle.

Verification (WAIT_CYCLES=4, BASE_ADDR=1024, memory reset to mem[i]=i)
REQ-034 Load test: rd_en=1 with address=1044 at cycle 0. Required: ready=0 in cycles 0-4; mem_read=1 and mem_address=5 in cycles 1-4; ready=1 and read_data=5 in cycle 5.
REQ-035 Store then load: wr_en=1, address=1032, write_data=0xDEADBEEF. Required: exactly one mem_write pulse, in cycle 4, with mem_address=2. A following load of 1032 returns 0xDEADBEEF.
REQ-036 Simultaneous request: rd_en=1 and wr_en=1, address=1028, write_data=0x12345678. Required: mem_read never 1; one write to word 1; read_data unchanged.
REQ-037 Reset mid-access: a store to 1040 is started and rst=1 in cycle 2. Required: IDLE and ready=1 in the next cycle; no mem_write pulse; word 4 still reads 4.
REQ-038 Unaligned and wrap: load address=1023. Required: mem_address=63 and read_data=63. Load address=1047. Required: mem_address=5.
REQ-039 Held request: rd_en held at 1 through DONE. Required: one IDLE cycle after DONE, then a second full 4-cycle ACCESS; no transaction starts from DONE.
